// File: rtl/qspi_arb_pkg.sv
// -----------------------------------------------------------------------------
// qspi_arb_pkg
// Shared types and constants for the qspi channel arbiter.
//   arb_state_t : arbiter FSM state encoding (IDLE, ISSUE, WAIT, DONE)
//   ARB_FIXED   : MODE value selecting fixed priority (channel 0 highest)
//   ARB_RR      : MODE value selecting round-robin arbitration
//   idx_width() : bits needed to hold a channel index (at least 1)
// -----------------------------------------------------------------------------
package qspi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } arb_state_t;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   // A single channel still needs a 1-bit index so port widths stay legal.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/qspi_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// qspi_arb_rr_pick
// Combinational rotating picker: returns the first set request at or after
// base_i, wrapping modulo N. Tying base_i to zero turns it into a plain
// lowest-index-wins priority encoder.
// Ports:
//   req_i  [N]  : request vector
//   base_i [BW] : starting index of the search (must be < N)
//   win_o  [N]  : one-hot winner (all zero when no request)
//   any_o       : at least one request is set
// -----------------------------------------------------------------------------
module qspi_arb_rr_pick
   import qspi_arb_pkg::*;
#(
   parameter int N  = 3,
   parameter int BW = idx_width(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [BW-1:0] base_i,
   output logic [N-1:0]  win_o,
   output logic          any_o
);

   int            pos;
   logic [BW-1:0] sel;
   logic          found;

   always_comb begin
      win_o = '0;
      found = 1'b0;
      pos   = 0;
      sel   = '0;
      for (int k = 0; k < N; k++) begin
         // Walk positions base, base+1, ... folding back past N-1.
         pos = int'(base_i) + k;
         if (pos >= N) pos = pos - N;
         sel = BW'(pos);
         if (!found && req_i[sel]) begin
            win_o[sel] = 1'b1;
            found      = 1'b1;
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/qspi_arb.sv
// -----------------------------------------------------------------------------
// qspi_arb
// N-channel arbiter in front of the qspi line-fill/flush engine. One request
// is latched in IDLE, driven to qspi, and completed with a one-cycle done
// pulse to its owner. MODE selects fixed priority or round-robin.
// Ports:
//   clk, reset      : clock, asynchronous active-low reset
//   req    [NCH]    : per-channel request level
//   write  [NCH]    : per-channel 1 = push line to memory, 0 = pull
//   mem    [NCH]    : per-channel 1 = rom/flash, 0 = ram
//   tag    [NCH*TW] : per-channel line tag, channel i = tag[i*TW +: TW]
//   gnt    [NCH]    : one-hot owner of the engine
//   done   [NCH]    : one-cycle completion pulse for the owner
//   m_req           : request to qspi, held until m_ack
//   m_write, m_mem  : latched write/mem of the owner
//   m_paddr [TW]    : latched tag of the owner
//   m_ack           : qspi accepted m_req (only looked at in ISSUE)
//   m_done          : qspi finished the line (only looked at in ISSUE/WAIT)
//   dbg_state       : current FSM state for observation
// Handshake: m_req stays high from the cycle after arbitration until the
// first cycle m_ack is seen high; m_done is accepted together with m_ack or
// any later cycle while waiting. done pulses exactly once per accepted line.
// -----------------------------------------------------------------------------
module qspi_arb
   import qspi_arb_pkg::*;
#(
   parameter int NCH         = 3,
   parameter int PA          = 22,
   parameter int LINE_LENGTH = 4,
   parameter int MODE        = ARB_RR,
   parameter int TW          = PA - $clog2(LINE_LENGTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NCH-1:0]    req,
   input  logic [NCH-1:0]    write,
   input  logic [NCH-1:0]    mem,
   input  logic [NCH*TW-1:0] tag,
   output logic [NCH-1:0]    gnt,
   output logic [NCH-1:0]    done,
   output logic              m_req,
   output logic              m_write,
   output logic              m_mem,
   output logic [TW-1:0]     m_paddr,
   input  logic              m_ack,
   input  logic              m_done,
   output arb_state_t        dbg_state
);

   localparam int IW = idx_width(NCH);

   // ---------------------------------------------------------------------
   // Registered state
   // ---------------------------------------------------------------------
   arb_state_t       state_q;
   logic [IW-1:0]    idx_q;
   logic [IW-1:0]    ptr_q;
   logic [NCH-1:0]   gnt_q;
   logic [NCH-1:0]   done_q;
   logic             m_req_q;
   logic             wr_q;
   logic             mem_q;
   logic [TW-1:0]    tag_q;

   // ---------------------------------------------------------------------
   // IDLE decode: pick a winner and mux its fields
   // ---------------------------------------------------------------------
   logic [IW-1:0]    pick_base;
   logic [NCH-1:0]   pick_win;
   logic             pick_any;
   logic [IW-1:0]    win_idx_d;
   logic             win_wr_d;
   logic             win_mem_d;
   logic [TW-1:0]    win_tag_d;

   // Fixed priority is the rotating picker with the search anchored at 0.
   assign pick_base = (MODE == ARB_RR) ? ptr_q : '0;

   qspi_arb_rr_pick #(
      .N  (NCH),
      .BW (IW)
   ) u_pick (
      .req_i  (req),
      .base_i (pick_base),
      .win_o  (pick_win),
      .any_o  (pick_any)
   );

   always_comb begin
      win_idx_d = '0;
      win_wr_d  = 1'b0;
      win_mem_d = 1'b0;
      win_tag_d = '0;
      for (int i = 0; i < NCH; i++) begin
         if (pick_win[i]) begin
            win_idx_d = IW'(i);
            win_wr_d  = write[i];
            win_mem_d = mem[i];
            win_tag_d = tag[i*TW +: TW];
         end
      end
   end

   // ---------------------------------------------------------------------
   // FSM with registered outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         ptr_q   <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         m_req_q <= 1'b0;
         wr_q    <= 1'b0;
         mem_q   <= 1'b0;
         tag_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_any) begin
                  // Owner fields freeze here until the transaction retires.
                  idx_q   <= win_idx_d;
                  gnt_q   <= pick_win;
                  wr_q    <= win_wr_d;
                  mem_q   <= win_mem_d;
                  tag_q   <= win_tag_d;
                  m_req_q <= 1'b1;
                  state_q <= ISSUE;
               end
            end
            ISSUE: begin
               if (m_ack) begin
                  m_req_q <= 1'b0;
                  if (m_done) begin
                     // Engine finished in the accept cycle: skip WAIT.
                     done_q  <= gnt_q;
                     state_q <= DONE;
                  end else begin
                     state_q <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (m_done) begin
                  // gnt_q is the owner's one-hot, so done can only hit it.
                  done_q  <= gnt_q;
                  state_q <= DONE;
               end
            end
            DONE: begin
               // Bubble cycle: owner sees done and may drop req before the
               // next arbitration in IDLE.
               gnt_q  <= '0;
               done_q <= '0;
               if (MODE == ARB_RR) begin
                  ptr_q <= (idx_q == IW'(NCH-1)) ? '0 : idx_q + 1'b1;
               end
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign done      = done_q;
   assign m_req     = m_req_q;
   assign m_write   = wr_q;
   assign m_mem     = mem_q;
   assign m_paddr   = tag_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_qspi_arb.sv
module tb_qspi_arb;
   import qspi_arb_pkg::*;

   localparam int NCH = 3;
   localparam int PA  = 22;
   localparam int LL  = 4;
   localparam int TW  = PA - $clog2(LL);
   localparam int SBW = NCH + 2 + TW;

   // ------------------------------------------------------------------
   // Clock / reset and shared stimulus
   // ------------------------------------------------------------------
   logic              clk    = 1'b0;
   logic              reset  = 1'b0;
   logic [NCH-1:0]    req    = '0;
   logic [NCH-1:0]    write  = '0;
   logic [NCH-1:0]    mem    = '0;
   logic [NCH*TW-1:0] tag    = '0;
   logic              m_ack  = 1'b0;
   logic              m_done = 1'b0;
   logic              sel_fx = 1'b0;

   always #5 clk = ~clk;

   // Round-robin instance
   logic [NCH-1:0] rr_gnt, rr_done;
   logic           rr_m_req, rr_m_write, rr_m_mem;
   logic [TW-1:0]  rr_m_paddr;
   arb_state_t     rr_state;

   // Fixed-priority instance
   logic [NCH-1:0] fx_gnt, fx_done;
   logic           fx_m_req, fx_m_write, fx_m_mem;
   logic [TW-1:0]  fx_m_paddr;
   arb_state_t     fx_state;

   qspi_arb #(.NCH(NCH), .PA(PA), .LINE_LENGTH(LL), .MODE(ARB_RR)) u_rr (
      .clk(clk), .reset(reset), .req(req), .write(write), .mem(mem), .tag(tag),
      .gnt(rr_gnt), .done(rr_done), .m_req(rr_m_req), .m_write(rr_m_write),
      .m_mem(rr_m_mem), .m_paddr(rr_m_paddr), .m_ack(m_ack), .m_done(m_done),
      .dbg_state(rr_state)
   );

   qspi_arb #(.NCH(NCH), .PA(PA), .LINE_LENGTH(LL), .MODE(ARB_FIXED)) u_fx (
      .clk(clk), .reset(reset), .req(req), .write(write), .mem(mem), .tag(tag),
      .gnt(fx_gnt), .done(fx_done), .m_req(fx_m_req), .m_write(fx_m_write),
      .m_mem(fx_m_mem), .m_paddr(fx_m_paddr), .m_ack(m_ack), .m_done(m_done),
      .dbg_state(fx_state)
   );

   // Observed instance
   logic [NCH-1:0] obs_gnt, obs_done;
   logic           obs_m_req, obs_m_write, obs_m_mem;
   logic [TW-1:0]  obs_m_paddr;
   arb_state_t     obs_state;

   assign obs_gnt     = sel_fx ? fx_gnt     : rr_gnt;
   assign obs_done    = sel_fx ? fx_done    : rr_done;
   assign obs_m_req   = sel_fx ? fx_m_req   : rr_m_req;
   assign obs_m_write = sel_fx ? fx_m_write : rr_m_write;
   assign obs_m_mem   = sel_fx ? fx_m_mem   : rr_m_mem;
   assign obs_m_paddr = sel_fx ? fx_m_paddr : rr_m_paddr;
   assign obs_state   = sel_fx ? fx_state   : rr_state;

   // ------------------------------------------------------------------
   // Scoreboard
   // ------------------------------------------------------------------
   int             n_chk  = 0;
   int             n_pass = 0;
   int             n_fail = 0;
   logic [SBW-1:0] exp_q[$];
   logic [SBW-1:0] sb_e;
   logic [TW-1:0]  last_tag;
   logic           last_w;
   logic           last_m;
   int             rr_order[4] = '{0, 1, 2, 0};

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
      end
   endtask

   function automatic logic [NCH-1:0] ch_oh(input int ch);
      logic [NCH-1:0] v;
      v     = '0;
      v[ch] = 1'b1;
      return v;
   endfunction

   // Expected owner record: {one-hot, write, mem, tag} as driven now.
   task automatic push_exp(input int ch);
      last_tag = tag[ch*TW +: TW];
      last_w   = write[ch];
      last_m   = mem[ch];
      exp_q.push_back({ch_oh(ch), last_w, last_m, last_tag});
   endtask

   // ------------------------------------------------------------------
   // Driver tasks
   // ------------------------------------------------------------------
   task automatic scramble();
      write = 3'($urandom_range(0, 7));
      mem   = 3'($urandom_range(0, 7));
      for (int i = 0; i < NCH; i++) tag[i*TW +: TW] = TW'($urandom);
   endtask

   // Called on the grant negedge; returns on the negedge done is visible.
   task automatic serve(input int ack_dly, input int done_dly);
      repeat (ack_dly) @(negedge clk);
      m_ack = 1'b1;
      @(negedge clk);
      m_ack = 1'b0;
      repeat (done_dly) @(negedge clk);
      m_done = 1'b1;
      @(negedge clk);
      m_done = 1'b0;
   endtask

   task automatic enter_reset(input logic fx);
      reset  = 1'b0;
      sel_fx = fx;
      req    = '0;
      m_ack  = 1'b0;
      m_done = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   // Monitor: every done pulse retires the oldest expected owner record.
   always @(negedge clk) begin
      if (reset && obs_done != '0) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_done", 64'(obs_done), 64'(0));
         end else begin
            sb_e = exp_q.pop_front();
            check("sb_txn", 64'({obs_done, obs_m_write, obs_m_mem, obs_m_paddr}), 64'(sb_e));
            check("sb_done_is_gnt", 64'(obs_done), 64'(obs_gnt));
         end
      end
   end

   // ------------------------------------------------------------------
   // Directed sequence
   // ------------------------------------------------------------------
   initial begin
      // Reset held with all channels requesting: everything quiet.
      enter_reset(1'b0);
      req = 3'b111;
      scramble();
      @(negedge clk);
      check("rst_gnt",     64'(obs_gnt),     64'(0));
      check("rst_done",    64'(obs_done),    64'(0));
      check("rst_m_req",   64'(obs_m_req),   64'(0));
      check("rst_m_write", 64'(obs_m_write), 64'(0));
      check("rst_m_mem",   64'(obs_m_mem),   64'(0));
      check("rst_m_paddr", 64'(obs_m_paddr), 64'(0));
      check("rst_state",   64'(obs_state),   64'(IDLE));

      // Release: channel 0 granted one cycle later.
      push_exp(0);
      reset = 1'b1;
      @(negedge clk);
      check("t1_gnt",     64'(obs_gnt),     64'(3'b001));
      check("t1_m_req",   64'(obs_m_req),   64'(1));
      check("t1_m_paddr", 64'(obs_m_paddr), 64'(last_tag));

      // Round-robin rotation with req held: 0,1,2,0.
      for (int r = 0; r < 4; r++) begin
         if (r > 0) begin
            scramble();
            push_exp(rr_order[r]);
            @(negedge clk);
            check("t2_gnt",     64'(obs_gnt),     64'(ch_oh(rr_order[r])));
            check("t2_m_paddr", 64'(obs_m_paddr), 64'(last_tag));
         end
         scramble();
         serve(3, 3);
         check("t2_done",        64'(obs_done),    64'(ch_oh(rr_order[r])));
         check("t2_paddr_held",  64'(obs_m_paddr), 64'(last_tag));
         @(negedge clk);
         check("t2_gnt_bubble",  64'(obs_gnt),  64'(0));
         check("t2_done_bubble", 64'(obs_done), 64'(0));
      end

      // Fixed priority: ch1 owns, ch0 arrives during WAIT and wins next.
      enter_reset(1'b1);
      req = 3'b110;
      scramble();
      push_exp(1);
      reset = 1'b1;
      @(negedge clk);
      check("t3_gnt_ch1", 64'(obs_gnt), 64'(3'b010));
      @(negedge clk);
      m_ack = 1'b1;
      @(negedge clk);
      m_ack = 1'b0;
      check("t3_wait_state", 64'(obs_state), 64'(WAIT));
      check("t3_wait_m_req", 64'(obs_m_req), 64'(0));
      req = 3'b111;
      push_exp(0);
      @(negedge clk);
      check("t3_still_ch1", 64'(obs_gnt), 64'(3'b010));
      m_done = 1'b1;
      @(negedge clk);
      m_done = 1'b0;
      check("t3_done_ch1", 64'(obs_done), 64'(3'b010));
      @(negedge clk);
      @(negedge clk);
      check("t3_gnt_ch0", 64'(obs_gnt), 64'(3'b001));
      req = 3'b100;
      push_exp(2);
      serve(0, 0);
      check("t3_done_ch0", 64'(obs_done), 64'(3'b001));
      @(negedge clk);
      @(negedge clk);
      check("t3_gnt_ch2", 64'(obs_gnt), 64'(3'b100));
      req = 3'b000;
      serve(2, 1);
      @(negedge clk);
      @(negedge clk);
      check("t3_idle_gnt",   64'(obs_gnt),   64'(0));
      check("t3_idle_state", 64'(obs_state), 64'(IDLE));

      // Owner withdraws and inputs change during ISSUE: transaction finishes.
      enter_reset(1'b0);
      req = 3'b010;
      scramble();
      push_exp(1);
      reset = 1'b1;
      @(negedge clk);
      check("t4_gnt", 64'(obs_gnt), 64'(3'b010));
      req = 3'b000;
      tag[TW +: TW] = ~tag[TW +: TW];
      write[1] = ~write[1];
      mem[1]   = ~mem[1];
      @(negedge clk);
      check("t4_m_req",   64'(obs_m_req),   64'(1));
      check("t4_m_paddr", 64'(obs_m_paddr), 64'(last_tag));
      check("t4_m_write", 64'(obs_m_write), 64'(last_w));
      check("t4_m_mem",   64'(obs_m_mem),   64'(last_m));
      serve(0, 0);
      check("t4_done", 64'(obs_done), 64'(3'b010));
      @(negedge clk);
      check("t4_done_one_cycle", 64'(obs_done), 64'(0));
      @(negedge clk);
      check("t4_no_regrant", 64'(obs_gnt), 64'(0));

      // m_ack with m_done together: straight to DONE, pointer wraps 2 -> 0.
      enter_reset(1'b0);
      req = 3'b100;
      scramble();
      push_exp(2);
      reset = 1'b1;
      @(negedge clk);
      check("t5_gnt_ch2", 64'(obs_gnt), 64'(3'b100));
      m_ack  = 1'b1;
      m_done = 1'b1;
      @(negedge clk);
      m_ack  = 1'b0;
      m_done = 1'b0;
      check("t5_state_done", 64'(obs_state), 64'(DONE));
      check("t5_done_ch2",   64'(obs_done),  64'(3'b100));
      @(negedge clk);
      check("t5_state_idle", 64'(obs_state), 64'(IDLE));
      req = 3'b011;
      push_exp(0);
      @(negedge clk);
      check("t5_wrap_gnt_ch0", 64'(obs_gnt), 64'(3'b001));
      serve(1, 0);
      push_exp(1);
      @(negedge clk);
      @(negedge clk);
      check("t5_next_gnt_ch1", 64'(obs_gnt), 64'(3'b010));
      req = 3'b000;
      serve(0, 2);
      @(negedge clk);
      // Stray handshakes while idle do nothing.
      m_ack  = 1'b1;
      m_done = 1'b1;
      @(negedge clk);
      m_ack  = 1'b0;
      m_done = 1'b0;
      check("t5_stray_state", 64'(obs_state), 64'(IDLE));
      check("t5_stray_gnt",   64'(obs_gnt),   64'(0));
      check("t5_stray_m_req", 64'(obs_m_req), 64'(0));

      // Reset in WAIT: outputs clear without a clock edge; stays idle.
      enter_reset(1'b0);
      req = 3'b001;
      scramble();
      push_exp(0);
      reset = 1'b1;
      @(negedge clk);
      check("t6_gnt", 64'(obs_gnt), 64'(3'b001));
      m_ack = 1'b1;
      @(negedge clk);
      m_ack = 1'b0;
      check("t6_wait_state", 64'(obs_state), 64'(WAIT));
      #2;
      reset = 1'b0;
      #1;
      check("t6_async_gnt",   64'(obs_gnt),   64'(0));
      check("t6_async_m_req", 64'(obs_m_req), 64'(0));
      check("t6_async_done",  64'(obs_done),  64'(0));
      check("t6_async_state", 64'(obs_state), 64'(IDLE));
      exp_q.delete();
      req = 3'b000;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      check("t6_idle_state", 64'(obs_state), 64'(IDLE));
      check("t6_idle_gnt",   64'(obs_gnt),   64'(0));
      check("t6_idle_m_req", 64'(obs_m_req), 64'(0));

      // Every expected transaction must have been retired.
      check("sb_drain", 64'(exp_q.size()), 64'(0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
